load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Runs one data-memory transaction per load/store over a req/gnt/rvalid bus with wait states.
- Stalls the single-cycle core until the access completes, then returns aligned, sign- or zero-extended load data to writeback.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states,
// RISC-V load/store funct3 codes and byte-enable patterns.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access decode, byte enables, store-lane
// replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        illegal,
    output logic        misaligned
);

    logic [31:0] shifted;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        illegal = 1'b0;
        if (is_load == is_store) begin
            illegal = 1'b1;
        end else if (is_load) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end
    end

    // funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be         = BE_WORD;
        wdata_lane = wdata;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be         = BE_BYTE << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: begin
                    be         = BE_WORD;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata_ext = {24'b0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'b0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/gnt/rvalid transaction per load/store, stalling
// the core until the access completes, errors, or times out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic        is_store_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [CNT_W-1:0] cnt_q;

    logic        in_idle;
    logic        a_is_load, a_is_store;
    logic [2:0]  a_funct3;
    logic [1:0]  a_addr_lo;
    logic [31:0] a_wdata;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        illegal, misaligned;
    logic        timeout, complete;

    // In IDLE the decoder sees the live instruction; afterwards the latched copy.
    assign in_idle    = (state_q == IDLE);
    assign a_is_load  = in_idle ? is_load_i  : is_load_q;
    assign a_is_store = in_idle ? is_store_i : is_store_q;
    assign a_funct3   = in_idle ? funct3_i   : funct3_q;
    assign a_addr_lo  = in_idle ? addr_i[1:0] : addr_q[1:0];
    assign a_wdata    = in_idle ? wdata_i    : wdata_q;

    lsu_align u_align (
        .is_load    (a_is_load),
        .is_store   (a_is_store),
        .funct3     (a_funct3),
        .addr_lo    (a_addr_lo),
        .wdata      (a_wdata),
        .mem_rdata  (mem_rdata_i),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign complete = ((state_q == REQ) && mem_gnt_i && mem_rvalid_i) ||
                      ((state_q == WAIT) && mem_rvalid_i);

    // Bus outputs exist only in REQ, so reset or any other state forces them to 0.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = BE_NONE;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                stall_o = valid_i;
                if (valid_i) state_d = (illegal || misaligned) ? DONE : REQ;
            end
            REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = is_store_q;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_be_o    = be;
                mem_wdata_o = wdata_lane;
                if (complete || timeout) state_d = DONE;
                else if (mem_gnt_i)      state_d = WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (complete || timeout) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                rdata_o = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the latched operands are reset along with the state so nothing stale can leak onto outputs after reset.
    // NOTE: sequential state is updated with <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        addr_q     <= addr_i;
                        wdata_q    <= wdata_i;
                        funct3_q   <= funct3_i;
                        is_load_q  <= is_load_i;
                        is_store_q <= is_store_i;
                        err_q      <= illegal || misaligned;
                        rdata_q    <= '0;
                        cnt_q      <= '0;
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (complete) begin
                        err_q   <= 1'b0;
                        rdata_q <= is_load_q ? rdata_ext : '0;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bus timing, lane handling,
// error paths, timeout and mid-transaction reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        valid_i    = 1'b1;
        is_load_i  = ld;
        is_store_i = st;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
    endtask

    task automatic idle_inputs();
        valid_i    = 1'b0;
        is_load_i  = 1'b0;
        is_store_i = 1'b0;
    endtask

    // Byte load from 0x103: gnt on the third REQ cycle, rvalid three cycles later.
    task automatic load_wait(input string tag, input logic [2:0] f3, input logic [31:0] exp);
        cyc(); issue(1'b1, 1'b0, f3, 32'h0000_0103, '0);
        smp(); check({tag, "_idle_req"}, {31'b0, mem_req_o}, 32'd0);
        cyc();
        smp(); check({tag, "_req1"}, {31'b0, mem_req_o}, 32'd1);
        check({tag, "_addr"}, mem_addr_o, 32'h0000_0100);
        cyc();
        smp(); check({tag, "_req2"}, {31'b0, mem_req_o}, 32'd1);
        cyc(); mem_gnt_i = 1'b1;
        smp(); check({tag, "_req3"}, {31'b0, mem_req_o}, 32'd1);
        cyc(); mem_gnt_i = 1'b0;
        smp(); check({tag, "_wait1"}, {30'b0, mem_req_o, stall_o}, 32'b01);
        cyc();
        smp(); check({tag, "_wait2"}, {30'b0, mem_req_o, done_o}, 32'b00);
        cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_1234;
        smp(); check({tag, "_wait3"}, {30'b0, mem_req_o, done_o}, 32'b00);
        cyc(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check({tag, "_done"}, {30'b0, done_o, err_o}, 32'b10);
        check({tag, "_rdata"}, rdata_o, exp);
        cyc(); idle_inputs();
    endtask

    initial begin
        #2;
        check("rst_outputs", {27'b0, stall_o, done_o, err_o, mem_req_o, mem_we_o}, 32'd0);
        check("rst_be", {28'b0, mem_be_o}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // lw 0x100, zero-wait memory
        cyc(); issue(1'b1, 1'b0, F3_W, 32'h0000_0100, '0);
        smp(); check("lw_stall_c0", {30'b0, stall_o, done_o}, 32'b10);
        cyc(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        smp(); check("lw_req", {29'b0, mem_req_o, mem_we_o, stall_o}, 32'b101);
        check("lw_be", {28'b0, mem_be_o}, 32'hF);
        check("lw_addr", mem_addr_o, 32'h0000_0100);
        check("lw_done_early", {31'b0, done_o}, 32'd0);
        cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check("lw_done", {29'b0, done_o, err_o, stall_o}, 32'b100);
        check("lw_rdata", rdata_o, 32'hDEAD_BEEF);
        cyc(); idle_inputs();
        smp(); check("lw_after", {30'b0, done_o, stall_o}, 32'd0);

        load_wait("lb", F3_B, 32'hFFFF_FF80);
        load_wait("lbu", F3_BU, 32'h0000_0080);

        // sh 0x202
        cyc(); issue(1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h0000_ABCD);
        smp(); check("sh_stall", {31'b0, stall_o}, 32'd1);
        cyc(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        smp(); check("sh_be", {28'b0, mem_be_o}, 32'b1100);
        check("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        check("sh_we_req", {30'b0, mem_we_o, mem_req_o}, 32'b11);
        check("sh_addr", mem_addr_o, 32'h0000_0200);
        cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check("sh_done", {30'b0, done_o, err_o}, 32'b10);
        check("sh_rdata", rdata_o, 32'd0);
        cyc(); idle_inputs();

        // sb 0x001
        cyc(); issue(1'b0, 1'b1, F3_B, 32'h0000_0001, 32'h1234_56A5);
        cyc(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        smp(); check("sb_be", {28'b0, mem_be_o}, 32'b0010);
        check("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        smp(); check("sb_done", {30'b0, done_o, err_o}, 32'b10);
        cyc(); idle_inputs();

        // lh 0x002, sign extension from the upper half
        cyc(); issue(1'b1, 1'b0, F3_H, 32'h0000_0002, '0);
        cyc(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_7F00;
        cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check("lh_done", {30'b0, done_o, err_o}, 32'b10);
        check("lh_rdata", rdata_o, 32'hFFFF_8001);
        cyc(); idle_inputs();

        // lw 0x102: misaligned, no bus request
        cyc(); issue(1'b1, 1'b0, F3_W, 32'h0000_0102, '0);
        smp(); check("mis_c0", {29'b0, mem_req_o, done_o, stall_o}, 32'b001);
        cyc();
        smp(); check("mis_done", {29'b0, mem_req_o, done_o, err_o}, 32'b011);
        check("mis_rdata", rdata_o, 32'd0);
        cyc(); idle_inputs();
        smp(); check("mis_after", {30'b0, mem_req_o, done_o}, 32'd0);

        // Illegal: load and store both set; load with funct3 011
        cyc(); issue(1'b1, 1'b1, F3_W, 32'h0000_0100, '0);
        cyc();
        smp(); check("ill_both", {29'b0, mem_req_o, done_o, err_o}, 32'b011);
        cyc(); idle_inputs();
        cyc(); issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, '0);
        cyc();
        smp(); check("ill_f3", {29'b0, mem_req_o, done_o, err_o}, 32'b011);
        cyc(); idle_inputs();

        // Timeout with gnt tied low
        cyc(); issue(1'b1, 1'b0, F3_W, 32'h0000_0100, '0);
        mem_rdata_i = 32'hCAFE_F00D;
        for (int i = 0; i < 16; i++) begin
            cyc();
            smp(); check("to_req", {30'b0, mem_req_o, done_o}, 32'b10);
        end
        cyc();
        smp(); check("to_done", {29'b0, mem_req_o, done_o, err_o}, 32'b011);
        check("to_rdata", rdata_o, 32'd0);
        cyc(); idle_inputs(); mem_rdata_i = '0;

        // Reset while in WAIT
        cyc(); issue(1'b1, 1'b0, F3_W, 32'h0000_0100, '0);
        cyc(); mem_gnt_i = 1'b1;
        cyc(); mem_gnt_i = 1'b0;
        smp(); check("rw_wait", {30'b0, mem_req_o, stall_o}, 32'b01);
        #2; idle_inputs(); rst_n = 1'b0;
        #1;
        check("rw_ctrl", {27'b0, stall_o, done_o, err_o, mem_req_o, mem_we_o}, 32'd0);
        check("rw_addr", mem_addr_o, 32'd0);
        check("rw_rdata", rdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBADB_AD00;
        smp(); check("rw_stray", {30'b0, done_o, stall_o}, 32'd0);
        cyc(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check("rw_stray2", {31'b0, done_o}, 32'd0);

        cyc(); issue(1'b1, 1'b0, F3_W, 32'h0000_0104, '0);
        cyc(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        smp(); check("rw_lw_addr", mem_addr_o, 32'h0000_0104);
        cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); check("rw_lw_done", {30'b0, done_o, err_o}, 32'b10);
        check("rw_lw_rdata", rdata_o, 32'h1234_5678);
        cyc(); idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected completion before 100000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
